cal_seq_div: RTL and testbench

- Sequential restoring divider for the calculator datapath: unsigned division computed one quotient bit per clock.
- It is the inverse operation of the calculator multiplier and sits beside the add/sub/mul units, driven by the calculator control logic through a start/done handshake.
- It exists so that division costs iterative registers rather than a large combinational array.

---
 rtl/cal_pkg.sv | 29 ++
 rtl/cal_div_step.sv | 38 +++
 rtl/cal_seq_div.sv | 118 +++++++++++
 tb/tb_cal_seq_div.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cal_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cal_pkg
//  Description : Shared types and constants for the calculator divider:
//                sequencer state encoding, default operand width and the
//                step-counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cal_pkg;

    // Divider sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cal_state_e;

    // Default operand width for the calculator datapath
    localparam int CAL_WIDTH = 4;

    // Bits needed to count 0..w iterations
    function automatic int cal_cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CAL_CNT_W = cal_cnt_width(CAL_WIDTH);

endpackage : cal_pkg
`default_nettype wire

// File: rtl/cal_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : cal_div_step
//  Description : One combinational restoring-division step. Shifts the next
//                dividend bit into the partial remainder, trial-subtracts the
//                divisor and yields the new remainder plus one quotient bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module cal_div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   r,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic             q_bit
);

    logic [WIDTH:0] w_rs;
    logic [WIDTH:0] w_d_ext;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    // Shift-in, trial subtract and restore-select for a single quotient bit.
    // The remainder's top bit is always zero between steps; folding it into
    // the compare keeps the full-width remainder consumed without altering
    // the result.
    always_comb begin
        w_rs    = {r[WIDTH-1:0], q_msb};
        w_d_ext = {1'b0, d};
        w_diff  = w_rs - w_d_ext;
        w_ge    = r[WIDTH] | (w_rs >= w_d_ext);
        q_bit   = w_ge;
        r_next  = w_ge ? w_diff : w_rs;
    end

endmodule : cal_div_step
`default_nettype wire

// File: rtl/cal_seq_div.sv
`default_nettype none
// ============================================================================
//  Module      : cal_seq_div
//  Description : Sequential unsigned restoring divider, one quotient bit per
//                clock, with a start/done handshake. Divide-by-zero is
//                resolved immediately (quot all ones, rem = dividend).
//  Revision    : 1.0 - initial release
// ============================================================================
module cal_seq_div
    import cal_pkg::*;
#(
    parameter int WIDTH = CAL_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero
);

    localparam int                 c_cnt_w = cal_cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    cal_state_e         r_state;
    logic [WIDTH:0]     r_r;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_d;
    logic [c_cnt_w-1:0] r_cnt;

    logic [WIDTH:0]     w_r_next;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_q_next;

    cal_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r      (r_r),
        .q_msb  (r_q[WIDTH-1]),
        .d      (r_d),
        .r_next (w_r_next),
        .q_bit  (w_qbit)
    );

    // Quotient register shifts left and takes the new quotient bit at bit 0
    always_comb begin
        w_q_next    = r_q << 1;
        w_q_next[0] = w_qbit;
    end

    // Sequencer: accept a job in IDLE, iterate WIDTH steps in RUN, pulse done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_r         <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_cnt       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (b == '0) begin
                            // Zero divisor needs no iterations
                            r_state     <= DONE;
                            done        <= 1'b1;
                            quot        <= '1;
                            rem         <= a;
                            div_by_zero <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_q     <= a;
                            r_d     <= b;
                            r_r     <= '0;
                            r_cnt   <= '0;
                        end
                    end
                end
                RUN: begin
                    r_r   <= w_r_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        // Final step: publish results straight from the step logic
                        r_state     <= DONE;
                        done        <= 1'b1;
                        quot        <= w_q_next;
                        rem         <= w_r_next[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : cal_seq_div
`default_nettype wire

// File: tb/tb_cal_seq_div.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cal_seq_div
//  Description : Scoreboard bench for cal_seq_div. The driver pushes the
//                expected result of each accepted job; a monitor pops and
//                compares whenever done is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cal_seq_div;

    localparam int WIDTH = 4;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             z;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             div_by_zero;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_done = 1'b0;

    cal_seq_div #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every done pulse must match the oldest outstanding job
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done) begin
                n_tests++;
                if (prev_done) begin
                    n_fail++;
                    $display("FAIL done_twice: done high in consecutive cycles, required single-cycle pulse");
                end
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done: got done with quot=%0d rem=%0d dbz=%0d, required no pulse",
                             quot, rem, div_by_zero);
                end else begin
                    e = sb.pop_front();
                    if (quot !== e.q || rem !== e.r || div_by_zero !== e.z) begin
                        n_fail++;
                        $display("FAIL result: got quot=%0d rem=%0d dbz=%0d, required quot=%0d rem=%0d dbz=%0d",
                                 quot, rem, div_by_zero, e.q, e.r, e.z);
                    end
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // Issue one job, check its done latency and busy duration; optionally
    // pulse a foreign start at cycle inj while the job is in flight.
    task automatic do_div(input logic [WIDTH-1:0] a_in, input logic [WIDTH-1:0] b_in,
                          input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                          input logic ez, input int inj);
        exp_t e;
        int   w;
        int   cyc;
        int   busy_cnt;
        int   exp_lat;
        bit   seen;
        e.q = eq; e.r = er; e.z = ez;
        w = 0;
        @(negedge clk);
        while (busy && w < 50) begin
            @(negedge clk);
            w++;
        end
        sb.push_back(e);
        a = a_in; b = b_in; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        exp_lat  = (b_in == '0) ? 0 : WIDTH;
        seen     = 1'b0;
        cyc      = 0;
        busy_cnt = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
                start = 1'b0;
            end else begin
                if (cyc == inj) begin
                    start = 1'b1; a = 4'd1; b = 4'd1;
                end else begin
                    start = 1'b0;
                end
                cyc++;
            end
        end
        start = 1'b0;
        n_tests++;
        if (!seen || cyc != exp_lat) begin
            n_fail++;
            $display("FAIL latency a=%0d b=%0d: done at cycle %0d (seen=%0d), required cycle %0d",
                     a_in, b_in, cyc, seen, exp_lat);
        end
        n_tests++;
        if (busy_cnt != exp_lat + 1) begin
            n_fail++;
            $display("FAIL busy_len a=%0d b=%0d: busy for %0d cycles, required %0d",
                     a_in, b_in, busy_cnt, exp_lat + 1);
        end
    endtask

    task automatic check_zero(input string name);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || quot !== '0 || rem !== '0 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: busy=%0d done=%0d quot=%0d rem=%0d dbz=%0d, required all zero",
                     name, busy, done, quot, rem, div_by_zero);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst_n = 1'b1;

        // Directed vectors
        do_div(4'd13, 4'd4, 4'd3, 4'd1, 1'b0, -1);
        do_div(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, -1);
        do_div(4'd3, 4'd7, 4'd0, 4'd3, 1'b0, -1);   // back-to-back
        do_div(4'd9, 4'd0, 4'd15, 4'd9, 1'b1, -1);
        do_div(4'd8, 4'd2, 4'd4, 4'd0, 1'b0, -1);
        do_div(4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 1);   // start during RUN ignored

        // Abort a job with an asynchronous reset
        @(negedge clk);
        a = 4'd12; b = 4'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async_abort");
        repeat (2) @(negedge clk);
        check_zero("held_in_reset");
        rst_n = 1'b1;
        do_div(4'd12, 4'd5, 4'd2, 4'd2, 1'b0, -1);

        // Full sweep against a reference model
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                if (ib == 0)
                    do_div(WIDTH'(ia), 4'd0, 4'd15, WIDTH'(ia), 1'b1, -1);
                else
                    do_div(WIDTH'(ia), WIDTH'(ib), WIDTH'(ia / ib), WIDTH'(ia % ib), 1'b0, -1);
            end
        end

        repeat (10) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL missing_done: %0d expected results never seen, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cal_seq_div
`default_nettype wire
